// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS load/store path.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int unsigned WORD_BYTES          = 4;
  localparam int unsigned BUS_TIMEOUT_DEFAULT = 16;

  function automatic logic is_word_aligned(input logic [1:0] byte_lsbs);
    return (byte_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Up-counter tracking how many REQ cycles an access has waited for bus_ack.
module bus_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the last allowed REQ cycle, so bus_req spans TIMEOUT_CYCLES cycles.
  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Bridges single-cycle MIPS loads/stores onto a variable-latency req/ack word bus,
// stalling the datapath until the access completes, times out or is rejected.
module dmem_bus_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              misalign_err,
  output logic              timeout_err
);

  mem_state_t        state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              bus_we_q;
  logic              misalign_q, timeout_q;

  logic access, aligned, latch_en, misalign_set, timeout_set;
  logic timer_clr, timer_en, timer_expired;

  assign access  = mem_read | mem_write;
  assign aligned = is_word_aligned(addr[1:0]);

  assign timer_en  = (state_q == REQ);
  assign timer_clr = (state_q != REQ) | bus_ack;

  bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    stall        = 1'b0;
    bus_req      = 1'b0;
    latch_en     = 1'b0;
    misalign_set = 1'b0;
    timeout_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            // Stall in the issue cycle itself so PC/REGwrite freeze immediately.
            stall    = 1'b1;
            latch_en = 1'b1;
            state_d  = REQ;
          end else begin
            misalign_set = 1'b1;
          end
        end
      end
      REQ: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (bus_ack) begin
          rdata_d = bus_we_q ? '0 : bus_rdata;
          state_d = DONE;
        end else if (timer_expired) begin
          rdata_d     = '0;
          timeout_set = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (latch_en) begin
        bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        bus_wdata_q <= wdata;
        bus_we_q    <= mem_write;
      end
      if (misalign_set) misalign_q <= 1'b1;
      if (timeout_set)  timeout_q  <= 1'b1;
    end
  end

  assign rdata        = (state_q == DONE) ? rdata_q : '0;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed self-checking bench for dmem_bus_ctrl with a responsive bus model.
module tb_dmem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        misalign_err, timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_bus_ctrl #(
    .DATA_W        (32),
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall       (stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .misalign_err(misalign_err),
    .timeout_err (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from the cycle after a posedge; ack_k = 0 means never ack.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_k, input logic [31:0] rdat,
                           output int n_stall, output int n_req, output logic [31:0] rd_done,
                           output logic we_seen, output logic [31:0] addr_seen,
                           output logic [31:0] wdata_seen, output int n_rd_bad,
                           output logic finished);
    int req_idx;
    n_stall = 0; n_req = 0; rd_done = '0; we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
    n_rd_bad = 0; finished = 1'b0; req_idx = 0;
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; bus_ack = 1'b0; bus_rdata = rdat;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) begin
        n_stall++;
        if (rdata !== '0) n_rd_bad++;
      end
      if (bus_req) begin
        n_req++;
        we_seen = bus_we; addr_seen = bus_addr; wdata_seen = bus_wdata;
      end
      if (!stall) begin
        rd_done  = rdata;
        finished = 1'b1;
      end
      @(posedge clk); #1;
      if (finished) break;
      if (bus_req) begin
        req_idx++;
        bus_ack = (req_idx == ack_k);
      end else begin
        bus_ack = 1'b0;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
  endtask

  int          ns, nr, nbad;
  logic [31:0] rdv, av, wdv;
  logic        wev, fin;

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_req", {31'd0, bus_req}, 32'd0);
    check_eq("rst_we", {31'd0, bus_we}, 32'd0);
    check_eq("rst_addr", bus_addr, 32'd0);
    check_eq("rst_wdata", bus_wdata, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Load, zero-wait bus.
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF, ns, nr, rdv, wev, av, wdv, nbad, fin);
    check_eq("ld_fin", {31'd0, fin}, 32'd1);
    check_eq("ld_stall", ns, 2);
    check_eq("ld_req", nr, 1);
    check_eq("ld_we", {31'd0, wev}, 32'd0);
    check_eq("ld_addr", av, 32'h40);
    check_eq("ld_rdata", rdv, 32'hDEADBEEF);
    check_eq("ld_rdata_stall", nbad, 0);
    @(negedge clk);
    check_eq("ld_rdata_idle", rdata, 32'd0);
    @(posedge clk); #1;

    // Store, ack in the 3rd REQ cycle.
    do_access(1'b0, 1'b1, 32'h100, 32'h12345678, 3, 32'hFFFFFFFF, ns, nr, rdv, wev, av, wdv,
              nbad, fin);
    check_eq("st_stall", ns, 4);
    check_eq("st_req", nr, 3);
    check_eq("st_we", {31'd0, wev}, 32'd1);
    check_eq("st_addr", av, 32'h100);
    check_eq("st_wdata", wdv, 32'h12345678);
    check_eq("st_rdata", rdv, 32'd0);

    // Misaligned load.
    do_access(1'b1, 1'b0, 32'h42, 32'h0, 1, 32'h11111111, ns, nr, rdv, wev, av, wdv, nbad, fin);
    check_eq("mis_stall", ns, 0);
    check_eq("mis_req", nr, 0);
    check_eq("mis_rdata", rdv, 32'd0);
    @(negedge clk);
    check_eq("mis_err", {31'd0, misalign_err}, 32'd1);
    check_eq("mis_no_tmo", {31'd0, timeout_err}, 32'd0);
    @(posedge clk); #1;

    // Both strobes: the write wins.
    do_access(1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 1, 32'h55555555, ns, nr, rdv, wev, av, wdv,
              nbad, fin);
    check_eq("both_we", {31'd0, wev}, 32'd1);
    check_eq("both_addr", av, 32'h80);
    check_eq("both_wdata", wdv, 32'hCAFEF00D);
    check_eq("both_rdata", rdv, 32'd0);
    check_eq("both_stall", ns, 2);

    // Spurious ack while idle.
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    check_eq("spur_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check_eq("spur_req", {31'd0, bus_req}, 32'd0);
    check_eq("spur_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    // Timeout: no ack ever.
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h77777777, ns, nr, rdv, wev, av, wdv, nbad, fin);
    check_eq("tmo_fin", {31'd0, fin}, 32'd1);
    check_eq("tmo_req", nr, 16);
    check_eq("tmo_stall", ns, 17);
    check_eq("tmo_rdata", rdv, 32'd0);
    @(negedge clk);
    check_eq("tmo_err", {31'd0, timeout_err}, 32'd1);
    check_eq("mis_sticky", {31'd0, misalign_err}, 32'd1);
    @(posedge clk); #1;

    // Reset during the 2nd REQ cycle.
    mem_read = 1'b1; addr = 32'h300; bus_ack = 1'b0;
    @(negedge clk);
    check_eq("rr_issue_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rr_req2", {31'd0, bus_req}, 32'd1);
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h99999999;
    @(negedge clk);
    check_eq("rr_req", {31'd0, bus_req}, 32'd0);
    check_eq("rr_stall", {31'd0, stall}, 32'd0);
    check_eq("rr_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check_eq("rr_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    do_access(1'b1, 1'b0, 32'h304, 32'h0, 2, 32'h0BADCAFE, ns, nr, rdv, wev, av, wdv, nbad, fin);
    check_eq("post_stall", ns, 3);
    check_eq("post_req", nr, 2);
    check_eq("post_addr", av, 32'h304);
    check_eq("post_rdata", rdv, 32'h0BADCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Load/store stage directly downstream of the MIPS datapath.
- Consumes ALU_result (address), write_data (store data) and the control unit's mem_read/mem_write strobes; returns read_data to the datapath's MEMtoREG mux.
- Bridges single-cycle load/store semantics to a variable-latency req/ack word bus and asserts stall so the datapath freezes PC and register write until the access completes.
- Also checks word alignment and enforces a bus timeout.

Parameters:
- DATA_W, 32, data bus and register width.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 16, maximum REQ cycles without bus_ack before the access is abandoned (must be ≥1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  load request from control unit, held for whole instruction.
- mem_write  input  1  store request from control unit, held for whole instruction.
- addr  input  ADDR_W  byte address (datapath ALU_result).
- wdata  input  DATA_W  store data (datapath write_data).
- rdata  output  DATA_W  load data to datapath read_data.
- stall  output  1  freeze PC and REGwrite while high.
- bus_req  output  1  bus request, held until ack or timeout.
- bus_we  output  1  1 = write transaction.
- bus_addr  output  ADDR_W  latched word address, addr[1:0] forced to 00.
- bus_wdata  output  DATA_W  latched store data.
- bus_ack  input  1  one-cycle completion strobe from memory.
- bus_rdata  input  DATA_W  read data, valid when bus_ack=1.
- misalign_err  output  1  sticky: misaligned access seen.
- timeout_err  output  1  sticky: bus timeout occurred.

Behaviour:
- Reset:
  - state=IDLE.
  - bus_req, bus_we, misalign_err, timeout_err all 0.
  - bus_addr, bus_wdata, rdata_q, timer all 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - With access = mem_read|mem_write and addr[1:0]==00: stall=1 combinationally in the same cycle; latch addr/wdata/we (we = mem_write); go to REQ.
  - mem_write has priority when both strobes are high (write issued, no read).
  - Misaligned access (addr[1:0]!=00): no bus transaction, stall=0, rdata=0, misalign_err set next edge; stay IDLE.
  - No access: stall=0.
- REQ:
  - bus_req=1, stall=1, timer increments each cycle.
  - bus_ack=1: capture bus_rdata into rdata_q (writes capture 0), clear timer, go to DONE. Ack on the first REQ cycle is legal.
  - Timer reaches TIMEOUT_CYCLES-1 with no ack: drop bus_req, rdata_q=0, set timeout_err, go to DONE.
- DONE:
  - stall=0, rdata=rdata_q; the datapath completes the instruction on this edge.
  - Always return to IDLE next cycle. The strobes seen in DONE belong to the completed instruction and are ignored.
- rdata is rdata_q in DONE and 0 otherwise.
- bus_ack outside REQ is ignored.
- Latency: ack in the k-th REQ cycle (k≥1) gives stall high for k+1 cycles; the instruction occupies k+2 cycles total.
- Zero-wait bus: 3-cycle load/store.
- Non-memory instructions never stall.
- Reset mid-REQ: bus_req low after the reset edge, no further ack honoured, stall=0.
- Timeout: bus_req is high for exactly TIMEOUT_CYCLES cycles.
- Error flags clear only on rst.

Decomposition:
- Shared package mips_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t.
  - WORD_BYTES=4.
  - BUS_TIMEOUT_DEFAULT=16.
- One sub-module, bus_timer:
  - Parameterised up-counter with clear and enable.
  - Width $clog2(TIMEOUT_CYCLES).
  - expired output.
- The FSM, latches and error flags stay in dmem_bus_ctrl.

Test Plan:
- Load from 0x0000_0040, bus_ack in the first REQ cycle with bus_rdata=0xDEADBEEF -> stall high 2 cycles, bus_we=0, bus_addr=0x40, rdata=0xDEADBEEF only in the DONE cycle.
- Store 0x1234_5678 to 0x0000_0100, ack after 3 REQ cycles -> bus_req high 3 cycles, bus_we=1, bus_wdata=0x12345678, stall high 4 cycles.
- Load from 0x0000_0042 -> no bus_req, stall=0, rdata=0, misalign_err=1 and stays 1 until rst.
- Load with no ack, TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, then DONE with rdata=0, timeout_err=1.
- mem_read=mem_write=1 at 0x80 -> write transaction (bus_we=1). Spurious bus_ack in IDLE -> no state change.
- rst asserted during the 2nd REQ cycle -> next cycle state IDLE, bus_req=0, stall=0; a following load completes normally.
